rate_ctrl: RTL and testbench
============================

RATE_CTRL -- requirements
Module: rate_ctrl

Interface
REQ-001 Parameter DEFAULT_DIV, default 32'd25000000, terminal count loaded at reset.
REQ-002 sCLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 EN  input  1  run enable; 1 = counting, 0 = idle.
REQ-005 DIV_REQ  input  1  rate-change request; a rising edge requests capture of DIV_VAL.
REQ-006 DIV_VAL  input  32  requested terminal count.
REQ-007 DIV_ACK  output  1  one-cycle pulse when the requested rate takes effect.
REQ-008 BUSY  output  1  high while a captured request awaits application.
REQ-009 CUR_DIV  output  32  terminal count currently in effect.
REQ-010 TICK  output  1  one-cycle pulse at each terminal count.
REQ-011 CLK  output  1  divided clock; toggles on each TICK.

Function
REQ-012 States: IDLE (EN=0) and RUN (EN=1); the state SHALL follow registered EN with one cycle latency.
REQ-013 RUN: cnt increments each cycle; when cnt==CUR_DIV, then cnt<=0, TICK=1 and CLK toggles; tick period = CUR_DIV+1 cycles; CLK period = 2*(CUR_DIV+1).
REQ-014 IDLE: cnt, TICK and CLK all held at 0; the first TICK after re-entering RUN occurs CUR_DIV+1 cycles after entry.
REQ-015 Capture: on a DIV_REQ rising edge with BUSY=0, store DIV_VAL in pending and set BUSY=1 next cycle; while BUSY=1, rising edges are ignored and DIV_VAL is not sampled.
REQ-016 DIV_VAL==0 SHALL be clamped to 1 at capture.
REQ-017 Apply in RUN: a pending value SHALL be loaded into CUR_DIV on the terminal-count cycle, provided it was pending at the start of that cycle; the TICK on that cycle still occurs; the next period uses the new value.
REQ-018 A request captured in the terminal-count cycle itself SHALL be applied at the following terminal count.
REQ-019 Apply in IDLE: a pending value SHALL be loaded on the cycle after capture.
REQ-020 On apply, BUSY<=0, and DIV_ACK SHALL be 1 for exactly the next cycle.
REQ-021 No glitches: TICK, CLK, DIV_ACK and BUSY SHALL be driven directly from flops.
REQ-022 EN falling while BUSY=1: the pending value SHALL be applied by the IDLE rule.

Reset
REQ-023 While RESET=1: cnt=0, CLK=0, TICK=0, DIV_ACK=0, BUSY=0, pending cleared, CUR_DIV=DEFAULT_DIV, state=IDLE, DIV_REQ edge detector=0.
REQ-024 RESET asserted mid-period or with a request pending SHALL discard all progress; no DIV_ACK SHALL be issued for a discarded request.

Configuration
REQ-025 Macro RATE_CTRL_TICKCNT_EN; defined: adds output TICK_COUNT [15:0], incremented on each TICK, wraps 16'hFFFF->0, cleared only by RESET.
REQ-026 RATE_CTRL_TICKCNT_EN undefined: the TICK_COUNT port and its counter are absent; all other behaviour is identical.

Structure
REQ-027 Shared include rate_defs.vh SHALL hold the state encodings (IDLE=1'b0, RUN=1'b1), the DEFAULT_DIV value and the DIV width (32).
REQ-028 One sub-module, div_counter, SHALL implement the counter: synchronous clear, terminal-compare input and one-cycle TC output; rate_ctrl holds the FSM, handshake and CLK flop.

Verification
REQ-029 DEFAULT_DIV=3, EN=1 after reset -> TICK every 4 cycles, CLK period 8, CUR_DIV=3.
REQ-030 RUN, DIV_REQ rising with DIV_VAL=1 mid-period -> BUSY=1, current period completes at 4 cycles, DIV_ACK pulses once, then TICK every 2 cycles.
REQ-031 DIV_REQ rising on the terminal-count cycle with DIV_VAL=5 -> one more 4-cycle period, then 6-cycle periods; second DIV_REQ edge while BUSY=1 -> ignored.
REQ-032 EN=0, DIV_REQ rising with DIV_VAL=0 -> CUR_DIV=1 two cycles after the edge, DIV_ACK pulses, CLK and TICK stay 0.
REQ-033 RESET pulse mid-period with BUSY=1 -> all outputs at reset values asynchronously, CUR_DIV=3, no DIV_ACK.
REQ-034 RATE_CTRL_TICKCNT_EN defined, DIV=1, 131072 ticks -> TICK_COUNT returns to 0 exactly twice, equals 0 at the end.

Source files
------------

// File: rtl/rate_ctrl_pkg.sv
// rtl/rate_ctrl_pkg.sv - rate_ctrl types, constants and divider clamp helper
package rate_ctrl_pkg;
`include "rate_defs.vh"

   localparam int DIV_W = `RATE_DIV_W;
   localparam logic [DIV_W-1:0] DEFAULT_DIV_P = `RATE_DEFAULT_DIV;
   localparam logic [DIV_W-1:0] DIV_ONE = 1;

   typedef enum logic {
      ST_IDLE = `RATE_ST_IDLE,
      ST_RUN  = `RATE_ST_RUN
   } state_t;

   // A zero terminal count would stall the divider, so it is promoted to 1.
   function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
      return (v == '0) ? DIV_ONE : v;
   endfunction

endpackage

// File: rtl/rate_ctrl_div_counter.sv
// rtl/rate_ctrl_div_counter.sv - div_counter: terminal-count counter with sync clear and registered TC pulse
module div_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic [W-1:0] term,
   output logic         hit,
   output logic         tc
);

   localparam logic [W-1:0] ONE = 1;

   logic [W-1:0] cnt;

   // hit marks the terminal-count cycle; tc is its registered copy one cycle later.
   assign hit = !clr && (cnt == term);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         tc  <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         tc  <= 1'b0;
      end else if (hit) begin
         cnt <= '0;
         tc  <= 1'b1;
      end else begin
         cnt <= cnt + ONE;
         tc  <= 1'b0;
      end
   end

endmodule

// File: rtl/rate_defs.vh
// rtl/rate_defs.vh - shared state encodings, default divider and divider width for rate_ctrl
`ifndef RATE_DEFS_VH
`define RATE_DEFS_VH

`define RATE_ST_IDLE     1'b0
`define RATE_ST_RUN      1'b1
`define RATE_DEFAULT_DIV 32'd25000000
`define RATE_DIV_W       32

`endif

// File: rtl/rate_ctrl.sv
// rtl/rate_ctrl.sv - programmable tick/clock divider with rate-change handshake
// Optional tick counter output enabled by RATE_CTRL_TICKCNT_EN.
module rate_ctrl
   import rate_ctrl_pkg::*;
#(
   parameter logic [DIV_W-1:0] DEFAULT_DIV = DEFAULT_DIV_P
) (
   input  logic             sCLK,
   input  logic             RESET,
   input  logic             EN,
   input  logic             DIV_REQ,
   input  logic [DIV_W-1:0] DIV_VAL,
   output logic             DIV_ACK,
   output logic             BUSY,
   output logic [DIV_W-1:0] CUR_DIV,
   output logic             TICK,
`ifdef RATE_CTRL_TICKCNT_EN
   output logic             CLK,
   output logic [15:0]      TICK_COUNT
`else
   output logic             CLK
`endif
);

   state_t           state, state_nxt;
   logic             req_q;
   logic [DIV_W-1:0] pending;
   logic             hit;
   logic             idle;
   logic             capture;
   logic             apply;

   always_ff @(posedge sCLK or posedge RESET) begin
      if (RESET) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Pending values are applied on a terminal count in RUN, or immediately in IDLE.
   always_comb begin
      state_nxt = state;
      idle      = 1'b0;
      capture   = 1'b0;
      apply     = 1'b0;
      state_nxt = EN ? ST_RUN : ST_IDLE;
      idle      = (state == ST_IDLE);
      capture   = DIV_REQ && !req_q && !BUSY;
      apply     = BUSY && (idle || hit);
   end

   div_counter #(.W(DIV_W)) u_cnt (
      .clk  (sCLK),
      .rst  (RESET),
      .clr  (idle),
      .term (CUR_DIV),
      .hit  (hit),
      .tc   (TICK)
   );

   always_ff @(posedge sCLK or posedge RESET) begin
      if (RESET) begin
         req_q   <= 1'b0;
         pending <= '0;
         BUSY    <= 1'b0;
         DIV_ACK <= 1'b0;
         CUR_DIV <= DEFAULT_DIV;
         CLK     <= 1'b0;
      end else begin
         req_q   <= DIV_REQ;
         DIV_ACK <= apply;
         if (capture) begin
            pending <= clamp_div(DIV_VAL);
            BUSY    <= 1'b1;
         end else if (apply) begin
            CUR_DIV <= pending;
            BUSY    <= 1'b0;
         end
         if (idle)     CLK <= 1'b0;
         else if (hit) CLK <= !CLK;
      end
   end

`ifdef RATE_CTRL_TICKCNT_EN
   always_ff @(posedge sCLK or posedge RESET) begin
      if (RESET)    TICK_COUNT <= 16'd0;
      else if (hit) TICK_COUNT <= TICK_COUNT + 16'd1;
   end
`endif

endmodule

// File: tb/tb_rate_ctrl.sv
// tb/tb_rate_ctrl.sv - directed self-checking bench for rate_ctrl
module tb_rate_ctrl;

   logic        sCLK;
   logic        RESET;
   logic        EN;
   logic        DIV_REQ;
   logic [31:0] DIV_VAL;
   logic        DIV_ACK;
   logic        BUSY;
   logic [31:0] CUR_DIV;
   logic        TICK;
   logic        CLK;
`ifdef RATE_CTRL_TICKCNT_EN
   logic [15:0] TICK_COUNT;
`endif

   int checks = 0;
   int errors = 0;

   rate_ctrl #(.DEFAULT_DIV(32'd3)) dut (
      .sCLK       (sCLK),
      .RESET      (RESET),
      .EN         (EN),
      .DIV_REQ    (DIV_REQ),
      .DIV_VAL    (DIV_VAL),
      .DIV_ACK    (DIV_ACK),
      .BUSY       (BUSY),
      .CUR_DIV    (CUR_DIV),
      .TICK       (TICK),
`ifdef RATE_CTRL_TICKCNT_EN
      .CLK        (CLK),
      .TICK_COUNT (TICK_COUNT)
`else
      .CLK        (CLK)
`endif
   );

   initial sCLK = 1'b0;
   always #5 sCLK = ~sCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Counts falling edges until TICK is seen high, bounded at 100.
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge sCLK);
         n++;
      end while (!TICK && n < 100);
   endtask

   int n;
   logic ack_seen;
`ifdef RATE_CTRL_TICKCNT_EN
   int zeros;
`endif

   initial begin
      RESET = 1'b1; EN = 1'b0; DIV_REQ = 1'b0; DIV_VAL = 32'd0;
      repeat (2) @(negedge sCLK);
      check("rst_tick", {31'd0, TICK}, 32'd0);
      check("rst_clk", {31'd0, CLK}, 32'd0);
      check("rst_ack", {31'd0, DIV_ACK}, 32'd0);
      check("rst_busy", {31'd0, BUSY}, 32'd0);
      check("rst_div", CUR_DIV, 32'd3);

      // default divider 3: first tick 5 edges after enabling, then every 4
      RESET = 1'b0; EN = 1'b1;
      wait_tick(n);  check("first_tick", n, 32'd5);
      check("clk_hi", {31'd0, CLK}, 32'd1);
      wait_tick(n);  check("period_def", n, 32'd4);
      check("clk_lo", {31'd0, CLK}, 32'd0);
      check("div_def", CUR_DIV, 32'd3);

      // request on the terminal-count cycle: one more 4-period, then 6
      repeat (3) @(negedge sCLK);
      DIV_REQ = 1'b1; DIV_VAL = 32'd5;
      @(negedge sCLK);
      check("tc_req_tick", {31'd0, TICK}, 32'd1);
      check("tc_req_busy", {31'd0, BUSY}, 32'd1);
      check("tc_req_div", CUR_DIV, 32'd3);
      DIV_REQ = 1'b0;
      @(negedge sCLK);
      DIV_REQ = 1'b1; DIV_VAL = 32'd9;
      @(negedge sCLK);
      DIV_REQ = 1'b0;
      wait_tick(n);  check("tc_req_rest", n, 32'd2);
      check("tc_apply_div", CUR_DIV, 32'd5);
      check("tc_apply_ack", {31'd0, DIV_ACK}, 32'd1);
      check("tc_apply_busy", {31'd0, BUSY}, 32'd0);
      wait_tick(n);  check("period_5", n, 32'd6);
      check("ignored_req", CUR_DIV, 32'd5);
      check("ack_once", {31'd0, DIV_ACK}, 32'd0);

      // mid-period request: current 6-period completes, then period 3
      @(negedge sCLK);
      DIV_REQ = 1'b1; DIV_VAL = 32'd2;
      @(negedge sCLK);
      check("mid_busy", {31'd0, BUSY}, 32'd1);
      DIV_REQ = 1'b0;
      wait_tick(n);  check("mid_rest", n, 32'd4);
      check("mid_div", CUR_DIV, 32'd2);
      check("mid_ack", {31'd0, DIV_ACK}, 32'd1);
      check("mid_busy_clr", {31'd0, BUSY}, 32'd0);
      wait_tick(n);  check("period_2", n, 32'd3);
      check("mid_ack_lo", {31'd0, DIV_ACK}, 32'd0);
      wait_tick(n);  check("period_2b", n, 32'd3);

      // idle request with zero value: clamped to 1, applied the cycle after capture
      EN = 1'b0;
      repeat (3) @(negedge sCLK);
      check("idle_tick", {31'd0, TICK}, 32'd0);
      check("idle_clk", {31'd0, CLK}, 32'd0);
      DIV_REQ = 1'b1; DIV_VAL = 32'd0;
      @(negedge sCLK);
      check("idle_busy", {31'd0, BUSY}, 32'd1);
      check("idle_div_old", CUR_DIV, 32'd2);
      @(negedge sCLK);
      check("idle_div_new", CUR_DIV, 32'd1);
      check("idle_ack", {31'd0, DIV_ACK}, 32'd1);
      check("idle_busy_clr", {31'd0, BUSY}, 32'd0);
      DIV_REQ = 1'b0;
      @(negedge sCLK);
      check("idle_ack_lo", {31'd0, DIV_ACK}, 32'd0);
      check("idle_tick2", {31'd0, TICK}, 32'd0);
      check("idle_clk2", {31'd0, CLK}, 32'd0);

      // re-entry: one cycle of EN latency plus CUR_DIV+1
      EN = 1'b1;
      wait_tick(n);  check("reentry", n, 32'd3);
      wait_tick(n);  check("period_1", n, 32'd2);

      // asynchronous reset with a request pending
      DIV_REQ = 1'b1; DIV_VAL = 32'd7;
      @(negedge sCLK);
      check("pre_rst_busy", {31'd0, BUSY}, 32'd1);
      #1 RESET = 1'b1;
      #1;
      check("arst_busy", {31'd0, BUSY}, 32'd0);
      check("arst_div", CUR_DIV, 32'd3);
      check("arst_tick", {31'd0, TICK}, 32'd0);
      check("arst_clk", {31'd0, CLK}, 32'd0);
      check("arst_ack", {31'd0, DIV_ACK}, 32'd0);
      @(negedge sCLK);
      DIV_REQ = 1'b0; EN = 1'b0; RESET = 1'b0;
      ack_seen = 1'b0;
      repeat (3) begin
         @(negedge sCLK);
         ack_seen = ack_seen | DIV_ACK;
      end
      check("post_rst_noack", {31'd0, ack_seen}, 32'd0);
      check("post_rst_div", CUR_DIV, 32'd3);
      check("post_rst_busy", {31'd0, BUSY}, 32'd0);

`ifdef RATE_CTRL_TICKCNT_EN
      check("tcnt_rst", {16'd0, TICK_COUNT}, 32'd0);
      DIV_REQ = 1'b1; DIV_VAL = 32'd1;
      repeat (2) @(negedge sCLK);
      DIV_REQ = 1'b0;
      check("tcnt_div", CUR_DIV, 32'd1);
      EN = 1'b1;
      zeros = 0;
      for (int i = 0; i < 131072; i++) begin
         wait_tick(n);
         if (TICK_COUNT == 16'd0) zeros++;
      end
      check("tcnt_wraps", zeros, 32'd2);
      check("tcnt_end", {16'd0, TICK_COUNT}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
